// File: rtl/mssd_pkg.sv
// MSSD shared definitions: frame FSM states, field widths and serial line levels.
// Imported by the frame transmitter and the MSSD receiver.
package mssd_pkg;
   typedef enum logic [2:0] {
      ST_IDLE, ST_START, ST_PORT, ST_COUNT, ST_DATA, ST_PARITY, ST_GAP
   } state_e;

   localparam int PORT_W = 2;
   localparam int CNT_W  = 4;
   localparam int DATA_W = 15;

   localparam logic START_LVL = 1'b0;
   localparam logic IDLE_LVL  = 1'b1;

   // Even parity over the header and the payload; bits above count are already zero.
   function automatic logic frame_parity(input logic [PORT_W-1:0] p,
                                         input logic [CNT_W-1:0]  c,
                                         input logic [DATA_W-1:0] d);
      return (^p) ^ (^c) ^ (^d);
   endfunction
endpackage

// File: rtl/mssd_bit_timer.sv
// Bit-cell timer: counts 2*HALF_PERIOD cycles per cell, gives the strobe phase
// and a one-cycle tick on the last cycle of each cell.
module mssd_bit_timer #(
   parameter int HALF_PERIOD = 5
) (
   input  logic clock,
   input  logic reset,
   input  logic en_i,
   input  logic clr_i,
   input  logic strobe_en_i,
   output logic phase_o,
   output logic bit_end_o
);
   localparam int CW = $clog2(2 * HALF_PERIOD);
   localparam logic [CW-1:0] LAST = CW'(2 * HALF_PERIOD - 1);
   localparam logic [CW-1:0] HALF = CW'(HALF_PERIOD);

   logic [CW-1:0] cnt_q, cnt_d;
   logic          phase_q, phase_d;

   // Phase is derived from the next count so the strobe register lines up with the cell.
   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (en_i) begin
         if (cnt_q == LAST) cnt_d = '0;
         else               cnt_d = cnt_q + CW'(1);
      end else begin
         cnt_d = cnt_q;
      end
      phase_d = strobe_en_i && (cnt_d >= HALF);
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         cnt_q   <= '0;
         phase_q <= 1'b0;
      end else begin
         cnt_q   <= cnt_d;
         phase_q <= phase_d;
      end
   end

   assign phase_o   = phase_q;
   assign bit_end_o = en_i && (cnt_q == LAST);
endmodule

// File: rtl/mssd_frame_tx.sv
// MSSD serial frame transmitter: start bit, port, count, payload, optional
// parity (MSSD_TX_PARITY_EN) and a one-cell idle gap.
module mssd_frame_tx
   import mssd_pkg::*;
#(
   parameter int HALF_PERIOD = 5
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        start,
   input  logic [1:0]  port,
   input  logic [3:0]  count,
   input  logic [14:0] data,
   output logic        ready,
   output logic        ser_out,
   output logic        bit_clk,
   output logic        done
);
   localparam int HDR_W = PORT_W + CNT_W;
   localparam logic [CNT_W-1:0] DATA_W_C = CNT_W'(DATA_W);

   state_e                   state_q, state_d;
   logic [CNT_W-1:0]         bit_cnt_q, bit_cnt_d;
   logic [CNT_W-1:0]         count_q, count_d;
   logic [HDR_W-1:0]         hdr_q, hdr_d;
   logic [DATA_W-1:0]        data_q, data_d;
   logic                     ser_q, ser_d;
   logic                     ready_q, ready_d;
   logic                     done_q, done_d;
   logic [DATA_W-1:0]        aligned_s;
   logic                     accept_s, bit_end_s, strobe_en_s, post_bit_s;

   // Payload is left-aligned so data[count-1] sits in the MSB and unsent bits fall off.
   assign aligned_s = data << (DATA_W_C - count);

`ifdef MSSD_TX_PARITY_EN
   localparam state_e POST_DATA = ST_PARITY;
   logic parity_q, parity_d;
   assign post_bit_s = parity_q;
`else
   localparam state_e POST_DATA = ST_GAP;
   assign post_bit_s = IDLE_LVL;
`endif

   // Next-state logic: ser_out only changes on a cell boundary (bit_end) or on accept.
   always_comb begin
      state_d   = state_q;
      bit_cnt_d = bit_cnt_q;
      count_d   = count_q;
      hdr_d     = hdr_q;
      data_d    = data_q;
      ser_d     = ser_q;
      done_d    = 1'b0;
      accept_s  = 1'b0;
`ifdef MSSD_TX_PARITY_EN
      parity_d  = parity_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               accept_s  = 1'b1;
               state_d   = ST_START;
               ser_d     = START_LVL;
               bit_cnt_d = '0;
               count_d   = count;
               hdr_d     = {port, count};
               data_d    = aligned_s;
`ifdef MSSD_TX_PARITY_EN
               parity_d  = frame_parity(port, count, aligned_s);
`endif
            end else begin
               ser_d = IDLE_LVL;
            end
         end
         ST_START: begin
            if (bit_end_s) begin
               state_d   = ST_PORT;
               ser_d     = hdr_q[HDR_W-1];
               hdr_d     = hdr_q << 1;
               bit_cnt_d = '0;
            end else begin
               state_d = ST_START;
            end
         end
         ST_PORT: begin
            if (bit_end_s) begin
               ser_d = hdr_q[HDR_W-1];
               hdr_d = hdr_q << 1;
               if (bit_cnt_q == CNT_W'(PORT_W - 1)) begin
                  state_d   = ST_COUNT;
                  bit_cnt_d = '0;
               end else begin
                  bit_cnt_d = bit_cnt_q + CNT_W'(1);
               end
            end else begin
               state_d = ST_PORT;
            end
         end
         ST_COUNT: begin
            if (bit_end_s) begin
               if (bit_cnt_q == CNT_W'(CNT_W - 1)) begin
                  bit_cnt_d = '0;
                  if (count_q == '0) begin
                     state_d = POST_DATA;
                     ser_d   = post_bit_s;
                  end else begin
                     state_d = ST_DATA;
                     ser_d   = data_q[DATA_W-1];
                     data_d  = data_q << 1;
                  end
               end else begin
                  ser_d     = hdr_q[HDR_W-1];
                  hdr_d     = hdr_q << 1;
                  bit_cnt_d = bit_cnt_q + CNT_W'(1);
               end
            end else begin
               state_d = ST_COUNT;
            end
         end
         ST_DATA: begin
            if (bit_end_s) begin
               if ((bit_cnt_q + CNT_W'(1)) == count_q) begin
                  state_d   = POST_DATA;
                  ser_d     = post_bit_s;
                  bit_cnt_d = '0;
               end else begin
                  ser_d     = data_q[DATA_W-1];
                  data_d    = data_q << 1;
                  bit_cnt_d = bit_cnt_q + CNT_W'(1);
               end
            end else begin
               state_d = ST_DATA;
            end
         end
         ST_PARITY: begin
            if (bit_end_s) begin
               state_d = ST_GAP;
               ser_d   = IDLE_LVL;
            end else begin
               state_d = ST_PARITY;
            end
         end
         ST_GAP: begin
            if (bit_end_s) begin
               state_d = ST_IDLE;
               ser_d   = IDLE_LVL;
               done_d  = 1'b1;
            end else begin
               state_d = ST_GAP;
            end
         end
         default: begin
            state_d = ST_IDLE;
            ser_d   = IDLE_LVL;
         end
      endcase
      ready_d = (state_d == ST_IDLE);
   end

   assign strobe_en_s = (state_d != ST_IDLE) && (state_d != ST_GAP);

   mssd_bit_timer #(.HALF_PERIOD(HALF_PERIOD)) u_timer (
      .clock       (clock),
      .reset       (reset),
      .en_i        (state_q != ST_IDLE),
      .clr_i       (accept_s),
      .strobe_en_i (strobe_en_s),
      .phase_o     (bit_clk),
      .bit_end_o   (bit_end_s)
   );

   // Frame state, field shift registers and registered line outputs.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q   <= ST_IDLE;
         bit_cnt_q <= '0;
         count_q   <= '0;
         hdr_q     <= '0;
         data_q    <= '0;
         ser_q     <= IDLE_LVL;
         ready_q   <= 1'b1;
         done_q    <= 1'b0;
`ifdef MSSD_TX_PARITY_EN
         parity_q  <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         bit_cnt_q <= bit_cnt_d;
         count_q   <= count_d;
         hdr_q     <= hdr_d;
         data_q    <= data_d;
         ser_q     <= ser_d;
         ready_q   <= ready_d;
         done_q    <= done_d;
`ifdef MSSD_TX_PARITY_EN
         parity_q  <= parity_d;
`endif
      end
   end

   assign ready   = ready_q;
   assign ser_out = ser_q;
   assign done    = done_q;
endmodule

// File: tb/tb_mssd_frame_tx.sv
// Self-checking bench for mssd_frame_tx: table vectors, random frames against a
// cell-list model, back-to-back requests and a mid-frame reset.
module tb_mssd_frame_tx;
   localparam int H = 5;
`ifdef MSSD_TX_PARITY_EN
   localparam int PX = 1;
`else
   localparam int PX = 0;
`endif

   logic        clock = 1'b0;
   logic        reset, start;
   logic [1:0]  port;
   logic [3:0]  count;
   logic [14:0] data;
   logic        ready, ser_out, bit_clk, done;
   int          tests = 0;
   int          fails = 0;

   mssd_frame_tx #(.HALF_PERIOD(H)) dut (
      .clock(clock), .reset(reset), .start(start), .port(port), .count(count),
      .data(data), .ready(ready), .ser_out(ser_out), .bit_clk(bit_clk), .done(done)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic [1:0]  p;
      logic [3:0]  c;
      logic [14:0] d;
      int          lat;
      int          pulses;
      bit          mutate;
   } vec_t;
   vec_t tbl[4];

   task automatic check(input string name, input int got, input int exp);
      tests++;
      if (got != exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d", name, got, exp);
      end
   endtask

   // Model: list of cell levels in transmit order, cell k at bit k.
   function automatic logic [23:0] frame_cells(input logic [1:0] p, input logic [3:0] c,
                                               input logic [14:0] d);
      logic [23:0] v;
      int          n;
      logic        par;
      v = '0; n = 1; par = 1'b0;
      for (int i = 1; i >= 0; i--) begin v[n] = p[i]; par ^= p[i]; n++; end
      for (int i = 3; i >= 0; i--) begin v[n] = c[i]; par ^= c[i]; n++; end
      for (int i = int'(c) - 1; i >= 0; i--) begin v[n] = d[i]; par ^= d[i]; n++; end
      if (PX == 1) v[n] = par;
      return v;
   endfunction

   function automatic int frame_len(input logic [3:0] c);
      return 7 + int'(c) + PX;
   endfunction

   task automatic wait_ready();
      int k;
      k = 0;
      while (!ready && k < 1000) begin @(negedge clock); k++; end
      check("ready_wait", int'(ready), 1);
   endtask

   // Called at a negedge with the request driven; returns at the negedge of the done cycle.
   task automatic run_frame(input logic [1:0] p, input logic [3:0] c, input logic [14:0] d,
                            input bit mutate, output int lat, output int pulses);
      logic [23:0] cells;
      logic [3:0]  got, exp;
      logic        prev;
      int          n, tend;
      cells = frame_cells(p, c, d);
      n = frame_len(c);
      tend = (n + 1) * 2 * H;
      lat = -1; pulses = 0; prev = 1'b0;
      @(posedge clock);
      for (int t = 0; t <= tend; t++) begin
         @(negedge clock);
         if (t < n * 2 * H)  exp = {cells[t / (2 * H)], ((t % (2 * H)) >= H), 1'b0, 1'b0};
         else if (t < tend)  exp = 4'b1000;
         else                exp = 4'b1011;
         got = {ser_out, bit_clk, ready, done};
         tests++;
         if (got !== exp) begin
            fails++;
            $display("FAIL cell t=%0d ser/bclk/rdy/done got %b expected %b", t, got, exp);
         end
         if (bit_clk && !prev) pulses++;
         prev = bit_clk;
         if (done && lat < 0) lat = t;
         if (mutate) begin
            start = 1'($urandom); port = 2'($urandom);
            count = 4'($urandom); data = 15'($urandom);
         end else begin
            start = 1'b0;
         end
      end
   endtask

   initial begin
      int lat, pulses;
      logic [3:0] rc;
      reset = 1'b0; start = 1'b0; port = 2'd0; count = 4'd0; data = 15'd0;
      tbl[0] = '{2'd2, 4'd3,  15'b101,   110 + 10 * PX, 10 + PX, 1'b0};
      tbl[1] = '{2'd1, 4'd0,  15'h7FFF,  80 + 10 * PX,  7 + PX,  1'b0};
      tbl[2] = '{2'd0, 4'd15, 15'h5555,  230 + 10 * PX, 22 + PX, 1'b0};
      tbl[3] = '{2'd3, 4'd6,  15'h2A5C,  140 + 10 * PX, 13 + PX, 1'b1};

      repeat (3) @(negedge clock);
      check("rst_ser",   int'(ser_out), 1);
      check("rst_bclk",  int'(bit_clk), 0);
      check("rst_ready", int'(ready),   1);
      check("rst_done",  int'(done),    0);
      reset = 1'b1;
      @(negedge clock);

      for (int i = 0; i < 4; i++) begin
         wait_ready();
         port = tbl[i].p; count = tbl[i].c; data = tbl[i].d; start = 1'b1;
         run_frame(tbl[i].p, tbl[i].c, tbl[i].d, tbl[i].mutate, lat, pulses);
         start = 1'b0;
         check("vec_latency", lat, tbl[i].lat);
         check("vec_pulses", pulses, tbl[i].pulses);
      end

      // A start seen during the frame must not have been queued.
      repeat (4) @(negedge clock);
      check("no_queue", int'({ready, ser_out, bit_clk, done}), 4'b1100);

      // Back-to-back: second request raised in the done cycle.
      port = 2'd1; count = 4'd2; data = 15'b10; start = 1'b1;
      run_frame(2'd1, 4'd2, 15'b10, 1'b0, lat, pulses);
      check("b2b_first_lat", lat, (frame_len(4'd2) + 1) * 2 * H);
      port = 2'd2; count = 4'd1; data = 15'b1; start = 1'b1;
      run_frame(2'd2, 4'd1, 15'b1, 1'b0, lat, pulses);
      start = 1'b0;
      check("b2b_second_lat", lat, (frame_len(4'd1) + 1) * 2 * H);

      for (int r = 0; r < 8; r++) begin
         wait_ready();
         rc = 4'($urandom);
         port = 2'($urandom); count = rc; data = 15'($urandom); start = 1'b1;
         run_frame(port, count, data, 1'b0, lat, pulses);
         start = 1'b0;
         check("rand_latency", lat, (frame_len(rc) + 1) * 2 * H);
         check("rand_pulses", pulses, frame_len(rc));
      end

      // Mid-frame reset during the strobe-high half of cell 5.
      wait_ready();
      port = 2'd2; count = 4'd3; data = 15'b101; start = 1'b1;
      @(posedge clock);
      @(negedge clock);
      start = 1'b0;
      repeat (57) @(negedge clock);
      check("pre_rst_bclk", int'(bit_clk), 1);
      #1 reset = 1'b0;
      #1 check("async_rst", int'({ser_out, bit_clk, ready, done}), 4'b1010);
      @(negedge clock);
      @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
      wait_ready();
      port = tbl[0].p; count = tbl[0].c; data = tbl[0].d; start = 1'b1;
      run_frame(tbl[0].p, tbl[0].c, tbl[0].d, 1'b0, lat, pulses);
      start = 1'b0;
      check("post_rst_latency", lat, tbl[0].lat);
      check("post_rst_pulses", pulses, tbl[0].pulses);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: bench did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end
endmodule
